munoc_monitor_ctrl: RTL and testbench

Controller that sequences a bank of per-channel NoC traffic monitors (beat counters plus timeout detectors on valid/ready channels). It runs periodic measurement windows: clears the monitors, lets them count for a programmed number of cycles, then holds them and captures each channel's count serially into a result bank. Software or a debug master reads the bank through a simple request/acknowledge port. Timeout flags are collected into sticky status bits that drive one interrupt.

---
 rtl/munoc_monitor_ctrl_pkg.sv | 20 ++
 rtl/munoc_monitor_ctrl_if.sv | 18 +
 rtl/munoc_monitor_ctrl_bank.sv | 65 ++++++
 rtl/munoc_monitor_ctrl.sv | 119 +++++++++++
 tb/tb_munoc_monitor_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/munoc_monitor_ctrl_pkg.sv
// Shared types and constants for the munoc_monitor_ctrl NoC monitor sequencer.
package munoc_monitor_ctrl_pkg;

    localparam int unsigned DEF_NUM_CH    = 4;
    localparam int unsigned DEF_BW_CNT    = 16;
    localparam int unsigned DEF_BW_WINDOW = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StClear   = 2'd1,
        StMeasure = 2'd2,
        StCapture = 2'd3
    } state_t;

    // Index width that stays at least 1 bit for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/munoc_monitor_ctrl_if.sv
// Result-bank read port: request/acknowledge with 1-cycle latency.
interface munoc_monitor_ctrl_if #(
    parameter int unsigned NUM_CH = munoc_monitor_ctrl_pkg::DEF_NUM_CH,
    parameter int unsigned BW_CNT = munoc_monitor_ctrl_pkg::DEF_BW_CNT
) ();
    import munoc_monitor_ctrl_pkg::*;

    localparam int unsigned IW = idx_width(2 * NUM_CH);

    logic              rd_req;
    logic [IW-1:0]     rd_idx;
    logic              rd_ack;
    logic [BW_CNT-1:0] rd_data;

    modport master (output rd_req, output rd_idx, input rd_ack, input rd_data);
    modport slave  (input rd_req, input rd_idx, output rd_ack, output rd_data);

endinterface

// File: rtl/munoc_monitor_ctrl_bank.sv
// Result/peak register bank with a serial capture write port and a registered read port.
// Peak tracking is built only when MUNOC_MONITOR_CTRL_PEAK_EN is defined.
module munoc_monitor_ctrl_bank
    import munoc_monitor_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned BW_CNT = DEF_BW_CNT
) (
    input  logic                           i_clk,
    input  logic                           i_rstnn,
    input  logic                           i_wr_en,
    input  logic [idx_width(NUM_CH)-1:0]   i_wr_idx,
    input  logic [BW_CNT-1:0]              i_wr_data,
    munoc_monitor_ctrl_if.slave            rd
);

    logic [BW_CNT-1:0] r_result [NUM_CH];
`ifdef MUNOC_MONITOR_CTRL_PEAK_EN
    logic [BW_CNT-1:0] r_peak [NUM_CH];
`endif
    logic [BW_CNT-1:0] w_rd_val;
    logic              r_rd_ack;
    logic [BW_CNT-1:0] r_rd_data;

    // Out-of-range indices fall through to zero.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (int'(rd.rd_idx) == i) w_rd_val = r_result[i];
`ifdef MUNOC_MONITOR_CTRL_PEAK_EN
            if (int'(rd.rd_idx) == i + int'(NUM_CH)) w_rd_val = r_peak[i];
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstnn) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_result[i] <= '0;
`ifdef MUNOC_MONITOR_CTRL_PEAK_EN
                r_peak[i]   <= '0;
`endif
            end
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    if (int'(i_wr_idx) == i) begin
                        r_result[i] <= i_wr_data;
`ifdef MUNOC_MONITOR_CTRL_PEAK_EN
                        if (i_wr_data > r_peak[i]) r_peak[i] <= i_wr_data;
`endif
                    end
                end
            end
            r_rd_ack  <= rd.rd_req;
            r_rd_data <= rd.rd_req ? w_rd_val : '0;
        end
    end

    assign rd.rd_ack  = r_rd_ack;
    assign rd.rd_data = r_rd_data;

endmodule

// File: rtl/munoc_monitor_ctrl.sv
// Sequences NoC traffic monitors through clear/measure/capture windows and collects timeouts.
// Optional peak registers in the bank: define MUNOC_MONITOR_CTRL_PEAK_EN.
module munoc_monitor_ctrl
    import munoc_monitor_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned BW_CNT    = DEF_BW_CNT,
    parameter int unsigned BW_WINDOW = DEF_BW_WINDOW
) (
    input  logic                     i_clk,
    input  logic                     i_rstnn,
    input  logic                     i_cfg_enable,
    input  logic [BW_WINDOW-1:0]     i_cfg_window,
    input  logic [NUM_CH-1:0]        i_cfg_irq_mask,
    input  logic [NUM_CH*BW_CNT-1:0] i_mon_count,
    input  logic [NUM_CH-1:0]        i_mon_timeout,
    output logic                     o_mon_clear,
    output logic                     o_mon_hold,
    output logic                     o_win_done,
    input  logic [NUM_CH-1:0]        i_irq_clear,
    output logic                     o_irq,
    munoc_monitor_ctrl_if.slave      rd
);

    localparam int unsigned   CW       = idx_width(NUM_CH);
    localparam logic [CW-1:0] LAST_CAP = CW'(NUM_CH - 1);

    state_t                r_state, w_state_next;
    logic [BW_WINDOW-1:0]  r_cnt, w_cnt_next, w_win;
    logic [CW-1:0]         r_cap, w_cap_next;
    logic                  r_win_done, w_win_done_next;
    logic                  w_wr_en;
    logic [BW_CNT-1:0]     w_wr_data;
    logic [NUM_CH-1:0]     r_sticky;
    logic                  r_irq;

    assign w_win     = (i_cfg_window == '0) ? BW_WINDOW'(1) : i_cfg_window;
    assign w_wr_data = i_mon_count[int'(r_cap)*BW_CNT +: BW_CNT];

    // Dropping enable wins over every transition and suppresses the capture write.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cap_next      = r_cap;
        w_win_done_next = 1'b0;
        w_wr_en         = 1'b0;
        if (!i_cfg_enable) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: w_state_next = StClear;
                StClear: begin
                    w_cnt_next   = w_win - BW_WINDOW'(1);
                    w_state_next = StMeasure;
                end
                StMeasure: begin
                    if (r_cnt == '0) begin
                        w_state_next = StCapture;
                        w_cap_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - BW_WINDOW'(1);
                    end
                end
                StCapture: begin
                    w_wr_en    = 1'b1;
                    w_cap_next = r_cap + CW'(1);
                    if (r_cap == LAST_CAP) begin
                        w_state_next    = StClear;
                        w_win_done_next = 1'b1;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstnn) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_cap      <= '0;
            r_win_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cap      <= w_cap_next;
            r_win_done <= w_win_done_next;
        end
    end

    // Set has priority over write-1-to-clear.
    always_ff @(posedge i_clk) begin
        if (!i_rstnn) begin
            r_sticky <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sticky <= (r_sticky & ~i_irq_clear) | i_mon_timeout;
            r_irq    <= |(r_sticky & i_cfg_irq_mask);
        end
    end

    assign o_mon_clear = (r_state == StClear);
    assign o_mon_hold  = (r_state == StCapture);
    assign o_win_done  = r_win_done;
    assign o_irq       = r_irq;

    munoc_monitor_ctrl_bank #(
        .NUM_CH (NUM_CH),
        .BW_CNT (BW_CNT)
    ) u_bank (
        .i_clk     (i_clk),
        .i_rstnn   (i_rstnn),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_cap),
        .i_wr_data (w_wr_data),
        .rd        (rd)
    );

endmodule

// File: tb/tb_munoc_monitor_ctrl.sv
// Scoreboard bench for munoc_monitor_ctrl: window-phase reference model plus read queue.
module tb_munoc_monitor_ctrl;

    localparam int N   = 4;
    localparam int BC  = 16;
    localparam int BWW = 16;
    localparam int IW  = $clog2(2 * N);

    logic              clk = 1'b0;
    logic              rstnn;
    logic              en;
    logic [BWW-1:0]    win;
    logic [N-1:0]      mask;
    logic [N*BC-1:0]   mon_count;
    logic [N-1:0]      tmo;
    logic [N-1:0]      clr;
    logic              mon_clear, mon_hold, win_done, irq;

    always #5 clk = ~clk;

    munoc_monitor_ctrl_if #(.NUM_CH(N), .BW_CNT(BC)) rd_if ();

    munoc_monitor_ctrl #(
        .NUM_CH    (N),
        .BW_CNT    (BC),
        .BW_WINDOW (BWW)
    ) dut (
        .i_clk          (clk),
        .i_rstnn        (rstnn),
        .i_cfg_enable   (en),
        .i_cfg_window   (win),
        .i_cfg_irq_mask (mask),
        .i_mon_count    (mon_count),
        .i_mon_timeout  (tmo),
        .o_mon_clear    (mon_clear),
        .o_mon_hold     (mon_hold),
        .o_win_done     (win_done),
        .i_irq_clear    (clr),
        .o_irq          (irq),
        .rd             (rd_if.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: window position as a phase within a period of 1 + W + N cycles.
    bit       m_ready = 1'b0;
    bit       m_active;
    int       m_phase;
    int       m_w = 1;
    bit       m_wrapped;
    int       res_m [N];
    int       peak_m [N];
    bit [N-1:0] stk_m;
    bit       exp_clear, exp_hold, exp_done, exp_irq;
    int       exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cnt(input int k, input int v);
        mon_count[k*BC +: BC] = BC'(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step();
        int k, idx, v, c;
        if (!rstnn) begin
            m_active = 0; m_phase = 0; m_w = 1; m_wrapped = 0; stk_m = '0;
            for (int i = 0; i < N; i++) begin res_m[i] = 0; peak_m[i] = 0; end
            exp_clear = 0; exp_hold = 0; exp_done = 0; exp_irq = 0;
            exp_q.delete();
            m_ready = 1'b1;
            return;
        end
        if (rd_if.rd_req) begin
            idx = int'(rd_if.rd_idx);
            v = 0;
            if (idx < N) v = res_m[idx];
`ifdef MUNOC_MONITOR_CTRL_PEAK_EN
            else if (idx < 2 * N) v = peak_m[idx - N];
`endif
            exp_q.push_back(v);
        end
        exp_irq = |(stk_m & mask);
        stk_m = (stk_m & ~clr) | tmo;
        m_wrapped = 0;
        if (!en) begin
            m_active = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_phase = 0;
        end else begin
            if (m_phase == 0) m_w = (win == 0) ? 1 : int'(win);
            k = m_phase - (1 + m_w);
            if (k >= 0 && k < N) begin
                c = int'(mon_count[k*BC +: BC]);
                res_m[k] = c;
                if (c > peak_m[k]) peak_m[k] = c;
            end
            m_phase++;
            if (m_phase == 1 + m_w + N) begin
                m_phase = 0;
                m_wrapped = 1;
            end
        end
        exp_clear = m_active && (m_phase == 0);
        exp_hold  = m_active && (m_phase >= 1 + m_w) && (m_phase < 1 + m_w + N);
        exp_done  = m_wrapped;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares registered outputs mid-cycle and pops read expectations on rd_ack.
    initial begin
        int v;
        forever begin
            @(negedge clk);
            if (m_ready) begin
                chk("mon_clear", int'(mon_clear), int'(exp_clear));
                chk("mon_hold", int'(mon_hold), int'(exp_hold));
                chk("win_done", int'(win_done), int'(exp_done));
                chk("irq", int'(irq), int'(exp_irq));
                if (rd_if.rd_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_ack_unexpected", 1, 0);
                    end else begin
                        v = exp_q.pop_front();
                        chk("rd_data", int'(rd_if.rd_data), v);
                    end
                end else begin
                    chk("rd_data_idle", int'(rd_if.rd_data), 0);
                    if (exp_q.size() != 0) begin
                        v = exp_q.pop_front();
                        chk("rd_ack_missing", 0, 1);
                    end
                end
            end
        end
    end

    task automatic read_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_if.rd_req = 1'b1;
            rd_if.rd_idx = IW'(i);
            cyc();
        end
        rd_if.rd_req = 1'b0;
        cyc();
    endtask

    task automatic wait_phase(input int off);
        bit hit = 0;
        for (int t = 0; t < 300 && !hit; t++) begin
            if (m_active && m_phase == m_w + off) hit = 1;
            else cyc();
        end
        if (!hit) chk("phase_wait_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit hit = 0;
        for (int t = 0; t < 300 && !hit; t++) begin
            cyc();
            if (exp_done) hit = 1;
        end
        if (!hit) chk("win_done_wait_timeout", 0, 1);
    endtask

    initial begin
        rstnn = 1'b0; en = 1'b0; win = '0; mask = '0; mon_count = '0; tmo = '0; clr = '0;
        rd_if.rd_req = 1'b0; rd_if.rd_idx = '0;
        repeat (3) @(posedge clk);
        #1 rstnn = 1'b1;

        // Steady windows of length 10 with fixed counts.
        win = BWW'(10);
        for (int k = 0; k < N; k++) set_cnt(k, 100 + k);
        en = 1'b1;
        repeat (40) cyc();
        read_range(0, 2 * N - 1);

        // Zero window length behaves as one cycle.
        win = '0;
        repeat (20) cyc();

        // Abandon a capture on its second cycle.
        win = BWW'(3);
        for (int k = 0; k < N; k++) set_cnt(k, 200 + k);
        wait_phase(2);
        en = 1'b0;
        repeat (3) cyc();
        read_range(0, N - 1);

        // Sticky timeout and interrupt behaviour.
        mask = N'(4'b0100);
        tmo = N'(4'b0100); cyc(); tmo = '0;
        repeat (3) cyc();
        tmo = N'(4'b0100); clr = N'(4'b0100); cyc(); tmo = '0; clr = '0;
        repeat (2) cyc();
        clr = N'(4'b0100); cyc(); clr = '0;
        repeat (3) cyc();

        // Peak tracking on channel 1 across three windows.
        win = BWW'(2); en = 1'b1;
        set_cnt(1, 50); wait_done();
        set_cnt(1, 80); wait_done();
        set_cnt(1, 30); wait_done();
        read_range(1, 1);
        read_range(5, 5);

        // Reset in the middle of a measurement.
        wait_phase(-1);
        rstnn = 1'b0; cyc(); rstnn = 1'b1;
        read_range(0, 2 * N - 1);

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            rd_if.rd_req = 1'($urandom_range(0, 1));
            rd_if.rd_idx = IW'($urandom_range(0, 2 * N - 1));
            tmo = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            clr = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 19) == 0) mask = N'($urandom);
            if ($urandom_range(0, 3) == 0) set_cnt($urandom_range(0, N - 1), $urandom_range(0, 65535));
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) win = BWW'($urandom_range(0, 5));
            rstnn = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        rstnn = 1'b1;
        rd_if.rd_req = 1'b0;
        repeat (3) cyc();
        chk("rd_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
